// File: rtl/robertson_arbiter.sv
// robertson_arbiter: round-robin arbiter sharing one Robertson multiplier among N_REQ requesters.
// Operands are latched at grant and streamed to the multiplier; the product returns with a one-cycle ack.
module robertson_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   op_m,
    input  logic [8*N_REQ-1:0]   op_q,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          result,
    output logic                 err,
    output logic                 busy,
    output logic                 mul_enable,
    output logic [7:0]           mul_inbus,
    input  logic [7:0]           mul_outbus,
    input  logic                 mul_done
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, WAIT, READ_LO, RESP} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_grant;
    logic [7:0]       r_m;
    logic [7:0]       r_q;
    logic [7:0]       r_hi;
    logic [7:0]       r_cnt;
    logic [7:0]       r_mul_inbus;
    logic [15:0]      r_result;
    logic [N_REQ-1:0] r_ack;
    logic             r_err;
    logic             r_busy;
    logic             r_mul_enable;
    logic [PW-1:0]    w_grant;
    logic             w_any;
    logic [N_REQ-1:0] w_onehot;
    logic [7:0]       w_m_sel;
    logic [7:0]       w_q_sel;

    // Scan from the farthest offset back to ptr so the requester nearest ptr wins.
    always_comb begin
        w_grant = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[PW'((int'(r_ptr) + k) % N_REQ)]) w_grant = PW'((int'(r_ptr) + k) % N_REQ);
        end
    end

    assign w_any    = |req;
    assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
    assign w_m_sel  = op_m[{w_grant, 3'b000} +: 8];
    assign w_q_sel  = op_q[{w_grant, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_m          <= '0;
            r_q          <= '0;
            r_hi         <= '0;
            r_cnt        <= '0;
            r_mul_inbus  <= '0;
            r_result     <= '0;
            r_ack        <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_mul_enable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_grant      <= w_grant;
                    r_m          <= w_m_sel;
                    r_q          <= w_q_sel;
                    r_mul_inbus  <= w_m_sel;
                    r_mul_enable <= 1'b1;
                    r_busy       <= 1'b1;
                    r_state      <= LOAD_M;
                end
                LOAD_M: begin
                    r_mul_enable <= 1'b0;
                    r_mul_inbus  <= r_q;
                    r_state      <= LOAD_Q;
                end
                LOAD_Q: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        r_hi    <= mul_outbus;
                        r_state <= READ_LO;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == TO) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_ack    <= w_onehot;
                            r_state  <= RESP;
                        end
                    end
                end
                READ_LO: begin
                    r_result <= {r_hi, mul_outbus};
                    r_err    <= 1'b0;
                    r_ack    <= w_onehot;
                    r_state  <= RESP;
                end
                RESP: begin
                    r_ack   <= '0;
                    r_ptr   <= PW'((int'(r_grant) + 1) % N_REQ);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack        = r_ack;
    assign result     = r_result;
    assign err        = r_err;
    assign busy       = r_busy;
    assign mul_enable = r_mul_enable;
    assign mul_inbus  = r_mul_inbus;
endmodule

// File: tb/tb_robertson_arbiter.sv
// tb_robertson_arbiter: directed vectors and corner sequences for robertson_arbiter.
// A behavioural multiplier answers with a programmable number of WAIT cycles (0 = never).
module tb_robertson_arbiter;
    localparam int N = 4;

    logic           clk = 0;
    logic           rst_n = 0;
    logic [N-1:0]   req = 0;
    logic [8*N-1:0] op_m = 0;
    logic [8*N-1:0] op_q = 0;
    logic [N-1:0]   ack;
    logic [15:0]    result;
    logic           err;
    logic           busy;
    logic           mul_enable;
    logic [7:0]     mul_inbus;
    logic [7:0]     mul_outbus = 0;
    logic           md_model = 0;
    logic           md_stray = 0;
    wire            mul_done = md_model | md_stray;

    int total = 0;
    int bad = 0;
    int dly = 1;
    int phase = 0;
    int cnt_m = 0;
    int en_cnt = 0;
    int en_double = 0;
    int ack_cnt = 0;
    logic prev_en = 0;
    logic [7:0] m_cap = 0;
    logic [7:0] q_cap = 0;
    logic [15:0] prod = 0;
    wire signed [15:0] prod_now = $signed(m_cap) * $signed(mul_inbus);

    robertson_arbiter #(.N_REQ(N), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_m(op_m), .op_q(op_q),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .mul_enable(mul_enable), .mul_inbus(mul_inbus),
        .mul_outbus(mul_outbus), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: M with the enable, Q next cycle, done (high byte) after dly WAIT cycles, low byte after.
    always @(posedge clk) begin
        md_model <= 0;
        if (mul_enable) begin
            m_cap  <= mul_inbus;
            phase  <= 1;
            en_cnt <= en_cnt + 1;
        end else if (phase == 1) begin
            q_cap <= mul_inbus;
            prod  <= prod_now;
            if (dly == 1) begin
                md_model   <= 1;
                mul_outbus <= prod_now[15:8];
                phase      <= 3;
            end else if (dly == 0) begin
                phase <= 0;
            end else begin
                cnt_m <= dly - 1;
                phase <= 2;
            end
        end else if (phase == 2) begin
            cnt_m <= cnt_m - 1;
            if (cnt_m == 1) begin
                md_model   <= 1;
                mul_outbus <= prod[15:8];
                phase      <= 3;
            end
        end else if (phase == 3) begin
            mul_outbus <= prod[7:0];
            phase      <= 0;
        end
        if (mul_enable && prev_en) en_double <= en_double + 1;
        prev_en <= mul_enable;
        if (|ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output int cyc);
        @(negedge clk);
        cyc = 1;
        while (ack == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic set_ops(input int idx, input logic [7:0] m, input logic [7:0] q);
        op_m[8*idx +: 8] = m;
        op_q[8*idx +: 8] = q;
    endtask

    typedef struct {
        int          idx;
        logic [7:0]  m;
        logic [7:0]  q;
        int          d;
        logic [15:0] res;
    } vec_t;

    vec_t vt[7];

    initial begin
        int cyc;
        int e0;
        int a0;
        int ord[5];
        logic [15:0] rr[5];
        vt[0] = '{0, 8'hBB, 8'hD3, 8,  16'h0C21};
        vt[1] = '{1, 8'h07, 8'hFE, 1,  16'hFFF2};
        vt[2] = '{2, 8'h7F, 8'h7F, 3,  16'h3F01};
        vt[3] = '{3, 8'h80, 8'h80, 2,  16'h4000};
        vt[4] = '{1, 8'h80, 8'h7F, 5,  16'hC080};
        vt[5] = '{2, 8'h00, 8'h55, 1,  16'h0000};
        vt[6] = '{3, 8'hFF, 8'h01, 20, 16'hFFFF};
        ord = '{0, 1, 2, 3, 0};
        rr  = '{16'd0, 16'd15, 16'd30, 16'd45, 16'd0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_enable", mul_enable, 0);
        chk("rst_inbus", mul_inbus, 0);
        rst_n = 1;
        @(negedge clk);

        // Simultaneous req0/req2 with ptr=0, then ptr=3 proven by req0/req3 contest
        dly = 2;
        set_ops(0, 8'd2, 8'd3);
        set_ops(2, 8'd4, 8'd5);
        set_ops(3, 8'd1, 8'd9);
        req = 4'b0101;
        wait_ack(cyc);
        chk("pair_ack0", ack, 4'b0001);
        chk("pair_res0", result, 16'd6);
        req[0] = 0;
        wait_ack(cyc);
        chk("pair_ack2", ack, 4'b0100);
        chk("pair_res2", result, 16'd20);
        req = 4'b1001;
        wait_ack(cyc);
        chk("ptr3_ack", ack, 4'b1000);
        chk("ptr3_res", result, 16'd9);
        req[3] = 0;
        wait_ack(cyc);
        chk("ptr3_next_ack", ack, 4'b0001);
        chk("ptr3_next_res", result, 16'd6);
        req = 0;
        @(negedge clk);

        // Table of single-requester operations
        for (int i = 0; i < 7; i++) begin
            dly = vt[i].d;
            set_ops(vt[i].idx, vt[i].m, vt[i].q);
            e0 = en_cnt;
            req[vt[i].idx] = 1;
            wait_ack(cyc);
            req = 0;
            chk("vec_ack", ack, 1 << vt[i].idx);
            chk("vec_result", result, vt[i].res);
            chk("vec_err", err, 0);
            chk("vec_latency", cyc, 4 + vt[i].d);
            chk("vec_inbus_m", m_cap, vt[i].m);
            chk("vec_inbus_q", q_cap, vt[i].q);
            chk("vec_enables", en_cnt - e0, 1);
            @(negedge clk);
            chk("vec_ack_pulse", ack, 0);
            @(negedge clk);
            chk("vec_idle", busy, 0);
            chk("vec_result_hold", result, vt[i].res);
        end

        // Timeout, then a normal operation clears err
        dly = 0;
        set_ops(1, 8'd3, 8'd3);
        req = 4'b0010;
        wait_ack(cyc);
        req = 0;
        chk("to_ack", ack, 4'b0010);
        chk("to_err", err, 1);
        chk("to_result", result, 0);
        chk("to_latency", cyc, 23);
        repeat (3) @(negedge clk);
        chk("to_err_hold", err, 1);
        chk("to_ack_low", ack, 0);
        dly = 4;
        req = 4'b0010;
        wait_ack(cyc);
        req = 0;
        chk("after_to_ack", ack, 4'b0010);
        chk("after_to_err", err, 0);
        chk("after_to_result", result, 16'd9);
        chk("after_to_latency", cyc, 8);
        @(negedge clk);

        // Operand change after grant has no effect
        dly = 3;
        set_ops(1, 8'd7, 8'hFE);
        req = 4'b0010;
        @(negedge clk);
        op_m[15:8] = 8'h01;
        wait_ack(cyc);
        req = 0;
        chk("opchg_ack", ack, 4'b0010);
        chk("opchg_result", result, 16'hFFF2);
        chk("opchg_inbus_m", m_cap, 8'h07);
        chk("opchg_latency", cyc + 1, 7);
        @(negedge clk);

        // Reset while in WAIT, stray done ignored afterwards
        dly = 10;
        set_ops(0, 8'd5, 8'd5);
        a0 = ack_cnt;
        req = 4'b0001;
        repeat (5) @(negedge clk);
        chk("midrst_busy", busy, 1);
        rst_n = 0;
        req = 0;
        @(negedge clk);
        rst_n = 1;
        chk("midrst_busy0", busy, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_enable", mul_enable, 0);
        chk("midrst_inbus", mul_inbus, 0);
        chk("midrst_result", result, 0);
        chk("midrst_err", err, 0);
        md_stray = 1;
        @(negedge clk);
        md_stray = 0;
        repeat (20) @(negedge clk);
        chk("midrst_no_ack", ack_cnt - a0, 0);
        chk("midrst_still_idle", busy, 0);
        dly = 3;
        req = 4'b0001;
        wait_ack(cyc);
        req = 0;
        chk("rereq_ack", ack, 4'b0001);
        chk("rereq_result", result, 16'd25);
        chk("rereq_latency", cyc, 7);
        @(negedge clk);

        // All four held: round robin 0,1,2,3,0
        do_reset();
        dly = 1;
        for (int i = 0; i < N; i++) set_ops(i, 8'(i * 3), 8'd5);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(cyc);
            chk("rr_ack", ack, 1 << ord[i]);
            chk("rr_result", result, rr[i]);
        end
        req = 0;
        repeat (2) @(negedge clk);
        chk("no_double_enable", en_double, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
